// File: rtl/window_controller_pkg.sv
// Shared definitions for the register-window controller.
//   state_e         : sequencer states (idle, spill read/write, fill read/write, done)
//   RegSpillFirst   : first register of the spilled/filled block (r16)
//   SpillWords      : registers moved per spill/fill (r16..r31)
//   FrameBytes      : stack frame size in bytes for one spilled window
//   spill_reg()     : register number for a given word counter
package window_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSpillRd,
    StSpillWr,
    StFillRd,
    StFillWr,
    StDone
  } state_e;

  localparam int unsigned RegSpillFirst = 16;
  localparam int unsigned SpillWords    = 16;
  localparam int unsigned FrameBytes    = 64;

  function automatic logic [4:0] spill_reg(input logic [3:0] cnt);
    return 5'(RegSpillFirst) + {1'b0, cnt};
  endfunction

endpackage

// File: rtl/window_controller_win_index.sv
// Combinational window-index step and one-hot decode.
//   idx_i : starting window index
//   dec_i : 1 = step to idx-1, 0 = step to idx+1 (both wrap mod NWIN)
//   win_o : stepped window index
//   oh_o  : one-hot decode of win_o
module window_controller_win_index #(
  parameter int unsigned NWIN = 4,
  parameter int unsigned CWPW = 2
) (
  input  logic [CWPW-1:0] idx_i,
  input  logic            dec_i,
  output logic [CWPW-1:0] win_o,
  output logic [NWIN-1:0] oh_o
);

  // NWIN is a power of two, so the CWPW-bit wrap is the modulo.
  always_comb begin
    win_o = dec_i ? (idx_i - CWPW'(1)) : (idx_i + CWPW'(1));
    oh_o  = NWIN'(1) << win_o;
  end

endmodule

// File: rtl/window_controller.sv
// Register-window controller: owns CWP/WIM, sequences SAVE/RESTORE and performs the
// hardware spill (overflow) and fill (underflow) of r16..r31 through the data-memory port.
//   Clk/Clr            : clock, asynchronous active-low reset
//   Save/Restore       : one-cycle requests from decode
//   Wim_We/Wim_In      : direct WIM write
//   Cwp/Wim            : architectural window pointer and invalid mask
//   Busy/Done/Err      : spill/fill in progress, completion pulse, rejection pulse
//   Rf_*               : register-file port override while Busy (Rf_Own=1)
//   Mem_*              : request/ack memory port, request held until Mem_Ack
module window_controller
  import window_controller_pkg::*;
#(
  parameter int unsigned NWIN       = 4,
  parameter int unsigned CWPW       = 2,
  parameter logic [31:0] SPILL_BASE = 32'h0000_1000
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Save,
  input  logic            Restore,
  input  logic            Wim_We,
  input  logic [NWIN-1:0] Wim_In,
  output logic [CWPW-1:0] Cwp,
  output logic [NWIN-1:0] Wim,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic            Rf_Own,
  output logic [CWPW-1:0] Rf_Cwp,
  output logic [4:0]      Rf_RA,
  output logic [4:0]      Rf_RC,
  output logic            Rf_RFE,
  output logic [31:0]     Rf_Rin,
  input  logic [31:0]     Rf_Aout,
  output logic            Mem_Req,
  output logic            Mem_We,
  output logic [31:0]     Mem_Addr,
  output logic [31:0]     Mem_Wdata,
  input  logic [31:0]     Mem_Rdata,
  input  logic            Mem_Ack
);

  state_e          state_q, state_d;
  logic [CWPW-1:0] cwp_q, cwp_d;
  logic [NWIN-1:0] wim_q, wim_d;
  logic [31:0]     sp_q, sp_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CWPW-1:0] tgt_q, tgt_d;    // window that becomes CWP on completion
  logic            fill_q, fill_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rin_q, rin_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [CWPW-1:0] new_win, s_win, np1_win;
  logic [NWIN-1:0] new_oh, s_oh, np1_oh;
  logic            new_invalid, last_word;

  // Requested window: CWP-1 for SAVE, CWP+1 for RESTORE.
  window_controller_win_index #(.NWIN(NWIN), .CWPW(CWPW)) u_new (
    .idx_i (cwp_q),
    .dec_i (Save),
    .win_o (new_win),
    .oh_o  (new_oh)
  );

  // Spill victim: the window just below the target.
  window_controller_win_index #(.NWIN(NWIN), .CWPW(CWPW)) u_s (
    .idx_i (tgt_q),
    .dec_i (1'b1),
    .win_o (s_win),
    .oh_o  (s_oh)
  );

  // After a fill, the window above the target becomes the invalid one.
  window_controller_win_index #(.NWIN(NWIN), .CWPW(CWPW)) u_np1 (
    .idx_i (tgt_q),
    .dec_i (1'b0),
    .win_o (np1_win),
    .oh_o  (np1_oh)
  );

  logic unused_np1;
  assign unused_np1 = ^np1_win;

  assign new_invalid = |(wim_q & new_oh);
  assign last_word   = (cnt_q == 4'(SpillWords - 1));

  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    wim_d   = wim_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    fill_d  = fill_q;
    wdata_d = wdata_q;
    rin_d   = rin_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Wim_We) wim_d = Wim_In;
        if (Save || Restore) begin
          if ((Save && Restore) || Wim_We) begin
            err_d = 1'b1;
          end else if (!new_invalid) begin
            cwp_d  = new_win;
            done_d = 1'b1;
          end else if (Save) begin
            tgt_d   = new_win;
            fill_d  = 1'b0;
            sp_d    = sp_q - 32'(FrameBytes);
            cnt_d   = '0;
            state_d = StSpillRd;
          end else if (sp_q == SPILL_BASE) begin
            // Nothing has been spilled, so there is no frame to fill from.
            err_d = 1'b1;
          end else begin
            tgt_d   = new_win;
            fill_d  = 1'b1;
            cnt_d   = '0;
            state_d = StFillRd;
          end
        end
      end
      StSpillRd: begin
        wdata_d = Rf_Aout;
        state_d = StSpillWr;
      end
      StSpillWr: begin
        if (Mem_Ack) begin
          if (last_word) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = StSpillRd;
          end
        end
      end
      StFillRd: begin
        if (Mem_Ack) begin
          rin_d   = Mem_Rdata;
          state_d = StFillWr;
        end
      end
      StFillWr: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = StFillRd;
        end
      end
      StDone: begin
        cwp_d   = tgt_q;
        wim_d   = fill_q ? np1_oh : s_oh;
        if (fill_q) sp_d = sp_q + 32'(FrameBytes);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= StIdle;
      cwp_q   <= '0;
      wim_q   <= NWIN'(2);
      sp_q    <= SPILL_BASE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fill_q  <= 1'b0;
      wdata_q <= '0;
      rin_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      wim_q   <= wim_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      fill_q  <= fill_d;
      wdata_q <= wdata_d;
      rin_q   <= rin_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    Busy     = (state_q != StIdle);
    Rf_Own   = Busy;
    Rf_Cwp   = '0;
    Rf_RA    = '0;
    Rf_RC    = '0;
    Rf_RFE   = 1'b1;
    Mem_Req  = 1'b0;
    Mem_We   = 1'b0;
    Mem_Addr = '0;
    unique case (state_q)
      StSpillRd: begin
        Rf_Cwp = s_win;
        Rf_RA  = spill_reg(cnt_q);
      end
      StSpillWr: begin
        Rf_Cwp   = s_win;
        Mem_Req  = 1'b1;
        Mem_We   = 1'b1;
        Mem_Addr = sp_q + {26'd0, cnt_q, 2'b00};
      end
      StFillRd: begin
        Rf_Cwp   = tgt_q;
        Mem_Req  = 1'b1;
        Mem_Addr = sp_q + {26'd0, cnt_q, 2'b00};
      end
      StFillWr: begin
        Rf_Cwp = tgt_q;
        Rf_RC  = spill_reg(cnt_q);
        Rf_RFE = 1'b0;
      end
      default: ;
    endcase
  end

  assign Cwp       = cwp_q;
  assign Wim       = wim_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign Rf_Rin    = rin_q;
  assign Mem_Wdata = wdata_q;

endmodule

// File: tb/tb_window_controller.sv
// Self-checking bench for window_controller: register-file and memory models plus
// scoreboard queues of expected memory writes/reads and register-file writes.
module tb_window_controller;

  logic        Clk = 1'b0;
  logic        Clr, Save, Restore, Wim_We;
  logic [3:0]  Wim_In;
  logic [1:0]  Cwp, Rf_Cwp;
  logic [3:0]  Wim;
  logic        Busy, Done, Err, Rf_Own, Rf_RFE, Mem_Req, Mem_We, Mem_Ack;
  logic [4:0]  Rf_RA, Rf_RC;
  logic [31:0] Rf_Rin, Rf_Aout, Mem_Addr, Mem_Wdata, Mem_Rdata;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_exp_t;
  typedef struct {logic [1:0] win; logic [4:0] rc; logic [31:0] data;} rf_exp_t;
  wr_exp_t     wr_q[$];
  rf_exp_t     rfw_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] rf [4][32];
  logic [31:0] mem [1024];
  bit          rf_ready;

  window_controller u_dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Save      (Save),
    .Restore   (Restore),
    .Wim_We    (Wim_We),
    .Wim_In    (Wim_In),
    .Cwp       (Cwp),
    .Wim       (Wim),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .Rf_Own    (Rf_Own),
    .Rf_Cwp    (Rf_Cwp),
    .Rf_RA     (Rf_RA),
    .Rf_RC     (Rf_RC),
    .Rf_RFE    (Rf_RFE),
    .Rf_Rin    (Rf_Rin),
    .Rf_Aout   (Rf_Aout),
    .Mem_Req   (Mem_Req),
    .Mem_We    (Mem_We),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .Mem_Rdata (Mem_Rdata),
    .Mem_Ack   (Mem_Ack)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] init_val(input int w, input int r);
    return 32'hA500_0000 | 32'(w << 8) | 32'(r);
  endfunction

  // Register-file model: combinational read, write on rising edge when Rf_RFE is low.
  assign Rf_Aout = rf[Rf_Cwp][Rf_RA];
  always @(posedge Clk) begin
    if (!rf_ready) begin
      for (int w = 0; w < 4; w++)
        for (int r = 0; r < 32; r++) rf[w][r] <= init_val(w, r);
      rf_ready <= 1'b1;
    end else if (Rf_RFE === 1'b0) begin
      rf[Rf_Cwp][Rf_RC] <= Rf_Rin;
    end
  end

  // Advance to the next falling edge and act as the memory: ack after wait_n idle cycles.
  task automatic mem_step(input int wait_n, output bit acked, output bit we,
                          output logic [31:0] a, output logic [31:0] d);
    @(negedge Clk);
    acked = 1'b0; we = 1'b0; a = '0; d = '0;
    if (Mem_Ack) begin
      Mem_Ack = 1'b0;
      Mem_Rdata = '0;
    end else if (Mem_Req) begin
      if (wcnt >= wait_n) begin
        Mem_Ack = 1'b1;
        wcnt = 0;
        acked = 1'b1;
        we = Mem_We;
        a = Mem_Addr;
        if (Mem_We) begin
          d = Mem_Wdata;
          mem[Mem_Addr[11:2]] = Mem_Wdata;
        end else begin
          d = mem[Mem_Addr[11:2]];
          Mem_Rdata = mem[Mem_Addr[11:2]];
        end
      end else begin
        wcnt++;
      end
    end
  endtask

  // Hold a request for one rising edge; returns at the following falling edge.
  task automatic pulse(input bit s, input bit r, input bit we, input logic [3:0] wi);
    Save = s; Restore = r; Wim_We = we; Wim_In = wi;
    @(negedge Clk);
    Save = 1'b0; Restore = 1'b0; Wim_We = 1'b0; Wim_In = '0;
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (Cwp !== 2'd0) begin bad++; $display("FAIL reset_cwp got=%h want=0", Cwp); end
    total++; if (Wim !== 4'b0010) begin bad++; $display("FAIL reset_wim got=%b want=0010", Wim); end
    total++; if ({Busy, Done, Err, Rf_Own, Mem_Req, Mem_We} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {Busy, Done, Err, Rf_Own, Mem_Req, Mem_We});
    end
    total++; if (Rf_RFE !== 1'b1) begin bad++; $display("FAIL reset_rfe got=%b want=1", Rf_RFE); end
    total++; if (Mem_Addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", Mem_Addr); end
    Clr = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_fast_save();
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (Cwp !== 2'd3) begin bad++; $display("FAIL fast_cwp got=%0d want=3", Cwp); end
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL fast_done got=%b want=1", Done); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL fast_busy got=%b want=0", Busy); end
    @(negedge Clk);
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL fast_done_pulse got=%b want=0", Done); end
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (Cwp !== 2'd2) begin bad++; $display("FAIL fast_cwp2 got=%0d want=2", Cwp); end
  endtask

  task automatic test_spill();
    bit acked, we, fin;
    logic [31:0] a, d;
    int busy_n;
    wr_exp_t e;
    busy_n = 0; fin = 1'b0;
    for (int i = 0; i < 16; i++)
      wr_q.push_back('{addr: 32'hFC0 + 32'(4 * i), data: init_val(0, 16 + i)});
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 200; c++) begin
      if (!Busy) begin fin = 1'b1; break; end
      busy_n++;
      mem_step(0, acked, we, a, d);
      if (acked && we) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++; $display("FAIL spill_extra_write addr=%h data=%h want=none", a, d);
        end else begin
          e = wr_q.pop_front();
          if (a !== e.addr || d !== e.data) begin
            bad++; $display("FAIL spill_write got=%h/%h want=%h/%h", a, d, e.addr, e.data);
          end
        end
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL spill_timeout busy=%b want=0", Busy); end
    total++; if (busy_n != 33) begin bad++; $display("FAIL spill_busy_cycles got=%0d want=33", busy_n); end
    total++; if (wr_q.size() != 0) begin
      bad++; $display("FAIL spill_missing got=%0d want=0", wr_q.size()); wr_q.delete();
    end
    total++; if (Cwp !== 2'd1) begin bad++; $display("FAIL spill_cwp got=%0d want=1", Cwp); end
    total++; if (Wim !== 4'b0001) begin bad++; $display("FAIL spill_wim got=%b want=0001", Wim); end
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL spill_done got=%b want=1", Done); end
  endtask

  task automatic test_fill();
    bit acked, we, fin;
    logic [31:0] a, d, ea;
    int rfe_n, okw;
    rf_exp_t e;
    rfe_n = 0; fin = 1'b0; okw = 0;
    pulse(1'b0, 1'b0, 1'b1, 4'b0100);
    total++; if (Wim !== 4'b0100 || Err !== 1'b0) begin
      bad++; $display("FAIL wim_write got=%b err=%b want=0100 err=0", Wim, Err);
    end
    for (int i = 0; i < 16; i++) begin
      rd_q.push_back(32'hFC0 + 32'(4 * i));
      rfw_q.push_back('{win: 2'd2, rc: 5'(16 + i), data: init_val(0, 16 + i)});
    end
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    for (int c = 0; c < 400; c++) begin
      if (!Busy) begin fin = 1'b1; break; end
      if (Rf_RFE === 1'b0) begin
        rfe_n++;
        total++;
        if (rfw_q.size() == 0) begin
          bad++; $display("FAIL fill_extra_rfwrite rc=%0d want=none", Rf_RC);
        end else begin
          e = rfw_q.pop_front();
          if (Rf_Cwp !== e.win || Rf_RC !== e.rc || Rf_Rin !== e.data) begin
            bad++; $display("FAIL fill_rfwrite got=%0d/%0d/%h want=%0d/%0d/%h",
                            Rf_Cwp, Rf_RC, Rf_Rin, e.win, e.rc, e.data);
          end
        end
      end
      mem_step(3, acked, we, a, d);
      if (acked) begin
        total++;
        ea = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
        if (we || a !== ea) begin
          bad++; $display("FAIL fill_read got=%h we=%b want=%h we=0", a, we, ea);
        end
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL fill_timeout busy=%b want=0", Busy); end
    total++; if (rfe_n != 16) begin bad++; $display("FAIL fill_rfe_cycles got=%0d want=16", rfe_n); end
    total++; if (rd_q.size() != 0 || rfw_q.size() != 0) begin
      bad++; $display("FAIL fill_missing got=%0d/%0d want=0/0", rd_q.size(), rfw_q.size());
      rd_q.delete(); rfw_q.delete();
    end
    for (int i = 0; i < 16; i++) if (rf[2][16 + i] === init_val(0, 16 + i)) okw++;
    total++; if (okw != 16) begin bad++; $display("FAIL fill_rf_contents got=%0d want=16", okw); end
    total++; if (Cwp !== 2'd2) begin bad++; $display("FAIL fill_cwp got=%0d want=2", Cwp); end
    total++; if (Wim !== 4'b1000) begin bad++; $display("FAIL fill_wim got=%b want=1000", Wim); end
  endtask

  task automatic test_errors();
    pulse(1'b1, 1'b1, 1'b0, 4'd0);
    total++; if (Err !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL both_req_err got=%b/%b want=1/0", Err, Done);
    end
    total++; if (Cwp !== 2'd2 || Wim !== 4'b1000) begin
      bad++; $display("FAIL both_req_state got=%0d/%b want=2/1000", Cwp, Wim);
    end
    // RESTORE into window 3 (invalid) with an empty spill stack.
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    total++; if (Err !== 1'b1 || Cwp !== 2'd2 || Busy !== 1'b0) begin
      bad++; $display("FAIL empty_fill got=%b/%0d/%b want=1/2/0", Err, Cwp, Busy);
    end
    pulse(1'b1, 1'b0, 1'b1, 4'b0001);
    total++; if (Err !== 1'b1 || Wim !== 4'b0001 || Cwp !== 2'd2) begin
      bad++; $display("FAIL wim_vs_req got=%b/%b/%0d want=1/0001/2", Err, Wim, Cwp);
    end
    pulse(1'b0, 1'b0, 1'b1, 4'b1000);
  endtask

  task automatic test_busy_ignored();
    bit acked, we, fin, err_seen;
    logic [31:0] a, d;
    wr_exp_t e;
    fin = 1'b0; err_seen = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (Cwp !== 2'd0) begin bad++; $display("FAIL pre_spill2_cwp got=%0d want=0", Cwp); end
    // Window 2 now holds the data filled from window 0's frame.
    for (int i = 0; i < 16; i++)
      wr_q.push_back('{addr: 32'hFC0 + 32'(4 * i), data: init_val(0, 16 + i)});
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 200; c++) begin
      if (!Busy) begin fin = 1'b1; break; end
      if (Err) err_seen = 1'b1;
      if (c == 5) Save = 1'b1;
      mem_step(0, acked, we, a, d);
      Save = 1'b0;
      if (acked && we) begin
        total++;
        e = (wr_q.size() != 0) ? wr_q.pop_front() : '{addr: 32'hFFFF_FFFF, data: 32'd0};
        if (a !== e.addr || d !== e.data) begin
          bad++; $display("FAIL spill2_write got=%h/%h want=%h/%h", a, d, e.addr, e.data);
        end
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL spill2_timeout busy=%b want=0", Busy); end
    total++; if (err_seen || Err !== 1'b0) begin
      bad++; $display("FAIL busy_req_err got=%b want=0", err_seen | Err);
    end
    total++; if (Cwp !== 2'd3 || Wim !== 4'b0100) begin
      bad++; $display("FAIL spill2_state got=%0d/%b want=3/0100", Cwp, Wim);
    end
    total++; if (wr_q.size() != 0) begin
      bad++; $display("FAIL spill2_missing got=%0d want=0", wr_q.size()); wr_q.delete();
    end
    // RESTORE wraps 3 -> 0 into a valid window.
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    total++; if (Cwp !== 2'd0 || Done !== 1'b1) begin
      bad++; $display("FAIL restore_wrap got=%0d/%b want=0/1", Cwp, Done);
    end
  endtask

  task automatic test_reset_mid_spill();
    bit acked, we, fin;
    logic [31:0] a, d;
    int acks;
    acks = 0; fin = 1'b0;
    Clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 200; c++) begin
      if (acks == 7 && Mem_Req && !Mem_Ack) begin fin = 1'b1; break; end
      mem_step((acks == 7) ? 1000 : 0, acked, we, a, d);
      if (acked) acks++;
    end
    wcnt = 0;
    total++; if (!fin || Mem_Addr !== 32'hFDC) begin
      bad++; $display("FAIL mid_spill_reach got=%b/%h want=1/00000fdc", fin, Mem_Addr);
    end
    Clr = 1'b0;
    #1;
    total++; if (Mem_Req !== 1'b0 || Busy !== 1'b0 || Rf_Own !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl got=%b/%b/%b want=0/0/0", Mem_Req, Busy, Rf_Own);
    end
    total++; if (Cwp !== 2'd0 || Wim !== 4'b0010) begin
      bad++; $display("FAIL abort_state got=%0d/%b want=0/0010", Cwp, Wim);
    end
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    // Stack pointer must be back at its base: RESTORE into invalid window 1 is rejected.
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    total++; if (Err !== 1'b1 || Busy !== 1'b0 || Cwp !== 2'd0) begin
      bad++; $display("FAIL abort_sp got=%b/%b/%0d want=1/0/0", Err, Busy, Cwp);
    end
  endtask

  initial begin
    Clr = 1'b0; Save = 1'b0; Restore = 1'b0; Wim_We = 1'b0; Wim_In = '0;
    Mem_Ack = 1'b0; Mem_Rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_fast_save();
    test_spill();
    test_fill();
    test_errors();
    test_busy_ignored();
    test_reset_mid_spill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
